// File: rtl/qsram_access_controller.sv
// qsram_access_controller
// Front end for a single SDR QSRAM macro: round-robin arbitration between two
// requesters, periodic refresh bursts, and tagged read responses. Every pin
// toward the memory is registered and decoded from the state being entered,
// so a command appears on the pins the cycle after its handshake.
module qsram_access_controller #(
  parameter int ADDR_WIDTH       = 4,
  parameter int DATA_WIDTH       = 8,
  parameter int REFRESH_INTERVAL = 64,
  parameter int REFRESH_CYCLES   = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Req0Valid,
  input  logic                  Req0Write,
  input  logic [ADDR_WIDTH-1:0] Req0Addr,
  input  logic [DATA_WIDTH-1:0] Req0WData,
  output logic                  Req0Ready,
  input  logic                  Req1Valid,
  input  logic                  Req1Write,
  input  logic [ADDR_WIDTH-1:0] Req1Addr,
  input  logic [DATA_WIDTH-1:0] Req1WData,
  output logic                  Req1Ready,
  output logic                  RspValid,
  output logic                  RspId,
  output logic [DATA_WIDTH-1:0] RspData,
  output logic [ADDR_WIDTH-1:0] QAddress,
  output logic                  QEnable,
  output logic                  QRead,
  output logic                  QWrite,
  output logic                  QRefresh,
  output logic [DATA_WIDTH-1:0] QDataOut,
  output logic                  QDataOutEn,
  input  logic [DATA_WIDTH-1:0] QDataIn,
  output logic                  RefreshMissed
);

  localparam int CW = $clog2(REFRESH_INTERVAL);
  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_RELOAD  = CW'(REFRESH_INTERVAL - 1);
  localparam logic [RW-1:0] RCNT_RELOAD = RW'(REFRESH_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_REFRESH = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [RW-1:0]         rcnt_reg, rcnt_next;
  logic                  pending_reg, pending_next;
  logic                  missed_reg, missed_next;
  logic                  last_grant_reg, last_grant_next;
  logic [ADDR_WIDTH-1:0] lat_addr_reg, lat_addr_next;
  logic [DATA_WIDTH-1:0] lat_data_reg, lat_data_next;
  logic                  lat_write_reg, lat_write_next;
  logic                  lat_id_reg, lat_id_next;

  logic [ADDR_WIDTH-1:0] q_addr_reg, q_addr_next;
  logic                  q_en_reg, q_en_next;
  logic                  q_read_reg, q_read_next;
  logic                  q_write_reg, q_write_next;
  logic                  q_refresh_reg, q_refresh_next;
  logic [DATA_WIDTH-1:0] q_dout_reg, q_dout_next;
  logic                  q_douten_reg, q_douten_next;

  logic                  rsp_valid_reg, rsp_valid_next;
  logic                  rsp_id_reg, rsp_id_next;
  logic [DATA_WIDTH-1:0] rsp_data_reg, rsp_data_next;

  // Requester views as small vectors so both sides share one arbitration rule
  logic [1:0]            valid_vec;
  logic [1:0]            write_vec;
  logic [ADDR_WIDTH-1:0] addr_vec [2];
  logic [DATA_WIDTH-1:0] data_vec [2];
  logic [1:0]            grant_vec;
  logic [1:0]            ready_vec;
  logic                  idle_free;

  assign valid_vec   = {Req1Valid, Req0Valid};
  assign write_vec   = {Req1Write, Req0Write};
  assign addr_vec[0] = Req0Addr;
  assign addr_vec[1] = Req1Addr;
  assign data_vec[0] = Req0WData;
  assign data_vec[1] = Req1WData;

  // Pending refresh blocks new grants so it wins against waiting requests
  assign idle_free = (state_reg == ST_IDLE) && !pending_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_arb
      // Win when alone, or on a tie when the other side was granted last
      assign grant_vec[gi] = valid_vec[gi] &&
                             (!valid_vec[1-gi] || (last_grant_reg != 1'(gi)));
      assign ready_vec[gi] = idle_free && grant_vec[gi];
    end
  endgenerate

  assign Req0Ready = ready_vec[0];
  assign Req1Ready = ready_vec[1];

  // Next-state, refresh bookkeeping, and pin decode of the state being entered
  always_comb begin
    state_next      = state_reg;
    rcnt_next       = rcnt_reg;
    pending_next    = pending_reg;
    last_grant_next = last_grant_reg;
    lat_addr_next   = lat_addr_reg;
    lat_data_next   = lat_data_reg;
    lat_write_next  = lat_write_reg;
    lat_id_next     = lat_id_reg;

    cnt_next    = (cnt_reg == '0) ? CNT_RELOAD : cnt_reg - 1'b1;
    missed_next = (cnt_reg == '0) && pending_reg;

    case (state_reg)
      ST_IDLE: begin
        if (pending_reg) begin
          state_next   = ST_REFRESH;
          pending_next = 1'b0;
          rcnt_next    = RCNT_RELOAD;
        end else if (|valid_vec) begin
          state_next      = ST_ACCESS;
          lat_id_next     = grant_vec[1];
          last_grant_next = grant_vec[1];
          lat_addr_next   = addr_vec[grant_vec[1]];
          lat_data_next   = data_vec[grant_vec[1]];
          lat_write_next  = write_vec[grant_vec[1]];
        end
      end
      ST_ACCESS:  state_next = lat_write_reg ? ST_IDLE : ST_CAPTURE;
      ST_CAPTURE: state_next = ST_IDLE;
      default: begin
        if (rcnt_reg == '0) state_next = ST_IDLE;
        else                rcnt_next  = rcnt_reg - 1'b1;
      end
    endcase

    // An expiry always leaves a request pending, even if IDLE just took one
    if (cnt_reg == '0) pending_next = 1'b1;

    q_en_next      = (state_next == ST_ACCESS) || (state_next == ST_REFRESH);
    q_refresh_next = (state_next == ST_REFRESH);
    q_read_next    = (state_next == ST_ACCESS) && !lat_write_next;
    q_write_next   = (state_next == ST_ACCESS) && lat_write_next;
    q_douten_next  = q_write_next;
    q_addr_next    = (state_next == ST_ACCESS) ? lat_addr_next : '0;
    q_dout_next    = q_write_next ? lat_data_next : '0;

    rsp_valid_next = (state_reg == ST_CAPTURE);
    rsp_id_next    = (state_reg == ST_CAPTURE) ? lat_id_reg : rsp_id_reg;
    rsp_data_next  = (state_reg == ST_CAPTURE) ? QDataIn : rsp_data_reg;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= CNT_RELOAD;
      rcnt_reg       <= '0;
      pending_reg    <= 1'b0;
      missed_reg     <= 1'b0;
      last_grant_reg <= 1'b1;
      lat_addr_reg   <= '0;
      lat_data_reg   <= '0;
      lat_write_reg  <= 1'b0;
      lat_id_reg     <= 1'b0;
      q_addr_reg     <= '0;
      q_en_reg       <= 1'b0;
      q_read_reg     <= 1'b0;
      q_write_reg    <= 1'b0;
      q_refresh_reg  <= 1'b0;
      q_dout_reg     <= '0;
      q_douten_reg   <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_data_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      rcnt_reg       <= rcnt_next;
      pending_reg    <= pending_next;
      missed_reg     <= missed_next;
      last_grant_reg <= last_grant_next;
      lat_addr_reg   <= lat_addr_next;
      lat_data_reg   <= lat_data_next;
      lat_write_reg  <= lat_write_next;
      lat_id_reg     <= lat_id_next;
      q_addr_reg     <= q_addr_next;
      q_en_reg       <= q_en_next;
      q_read_reg     <= q_read_next;
      q_write_reg    <= q_write_next;
      q_refresh_reg  <= q_refresh_next;
      q_dout_reg     <= q_dout_next;
      q_douten_reg   <= q_douten_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_id_reg     <= rsp_id_next;
      rsp_data_reg   <= rsp_data_next;
    end
  end

  assign QAddress      = q_addr_reg;
  assign QEnable       = q_en_reg;
  assign QRead         = q_read_reg;
  assign QWrite        = q_write_reg;
  assign QRefresh      = q_refresh_reg;
  assign QDataOut      = q_dout_reg;
  assign QDataOutEn    = q_douten_reg;
  assign RspValid      = rsp_valid_reg;
  assign RspId         = rsp_id_reg;
  assign RspData       = rsp_data_reg;
  assign RefreshMissed = missed_reg;

endmodule

// File: tb/tb_qsram_access_controller.sv
// Directed bench for qsram_access_controller. Instance a (interval 16,
// 2-cycle refresh) covers access, arbitration, refresh and reset cases;
// instance b (interval 8, 8-cycle refresh) is saturated to force missed refreshes.
module tb_qsram_access_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance a signals
  logic       rst_a = 1'b1;
  logic       a_v0 = 0, a_w0 = 0, a_v1 = 0, a_w1 = 0;
  logic [3:0] a_addr0 = 0, a_addr1 = 0;
  logic [7:0] a_wd0 = 0, a_wd1 = 0;
  logic       a_r0, a_r1, a_rv, a_rid, a_en, a_rd, a_wr, a_rf, a_oe, a_miss;
  logic [7:0] a_rdata, a_dout, a_din;
  logic [3:0] a_qaddr;
  logic [7:0] mem_a [16];

  // Instance b signals
  logic       rst_b = 1'b1;
  logic       b_v0 = 0, b_w0 = 0, b_v1 = 0, b_w1 = 0;
  logic [3:0] b_addr0 = 0, b_addr1 = 0;
  logic [7:0] b_wd0 = 0, b_wd1 = 0;
  logic       b_r0, b_r1, b_rv, b_rid, b_en, b_rd, b_wr, b_rf, b_oe, b_miss;
  logic [7:0] b_rdata, b_dout;
  logic [7:0] b_din = 8'h00;
  logic [3:0] b_qaddr;

  qsram_access_controller #(.ADDR_WIDTH(4), .DATA_WIDTH(8),
                            .REFRESH_INTERVAL(16), .REFRESH_CYCLES(2)) dut_a (
    .Clock(clk), .Reset(rst_a),
    .Req0Valid(a_v0), .Req0Write(a_w0), .Req0Addr(a_addr0), .Req0WData(a_wd0), .Req0Ready(a_r0),
    .Req1Valid(a_v1), .Req1Write(a_w1), .Req1Addr(a_addr1), .Req1WData(a_wd1), .Req1Ready(a_r1),
    .RspValid(a_rv), .RspId(a_rid), .RspData(a_rdata),
    .QAddress(a_qaddr), .QEnable(a_en), .QRead(a_rd), .QWrite(a_wr), .QRefresh(a_rf),
    .QDataOut(a_dout), .QDataOutEn(a_oe), .QDataIn(a_din), .RefreshMissed(a_miss)
  );

  qsram_access_controller #(.ADDR_WIDTH(4), .DATA_WIDTH(8),
                            .REFRESH_INTERVAL(8), .REFRESH_CYCLES(8)) dut_b (
    .Clock(clk), .Reset(rst_b),
    .Req0Valid(b_v0), .Req0Write(b_w0), .Req0Addr(b_addr0), .Req0WData(b_wd0), .Req0Ready(b_r0),
    .Req1Valid(b_v1), .Req1Write(b_w1), .Req1Addr(b_addr1), .Req1WData(b_wd1), .Req1Ready(b_r1),
    .RspValid(b_rv), .RspId(b_rid), .RspData(b_rdata),
    .QAddress(b_qaddr), .QEnable(b_en), .QRead(b_rd), .QWrite(b_wr), .QRefresh(b_rf),
    .QDataOut(b_dout), .QDataOutEn(b_oe), .QDataIn(b_din), .RefreshMissed(b_miss)
  );

  // Memory model for instance a: data for a read command appears next cycle
  always @(posedge clk) begin
    if (rst_a) begin
      for (int i = 0; i < 16; i++) mem_a[i] <= 8'(i * 17);
    end else begin
      if (a_en && a_wr) mem_a[a_qaddr] <= a_dout;
      if (a_en && a_rd) a_din <= mem_a[a_qaddr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0: the cycle right after the last reset edge
  task automatic do_reset();
    rst_a = 1'b1;
    step();
    step();
    rst_a = 1'b0;
  endtask

  // Invariants and one line per accepted transaction, sampled mid-cycle
  always @(negedge clk) begin
    check("onehot_a", 32'($countones({a_rd, a_wr, a_rf}) <= 1), 1);
    check("onehot_b", 32'($countones({b_rd, b_wr, b_rf}) <= 1), 1);
    check("douten_a", 32'(!a_oe || a_wr), 1);
    check("douten_b", 32'(!b_oe || b_wr), 1);
    check("ready_excl_a", 32'(!(a_r0 && a_r1)), 1);
    check("ready_excl_b", 32'(!(b_r0 && b_r1)), 1);
    if (a_v0 && a_r0) $display("a: req0 %s addr %0d data %02h", a_w0 ? "write" : "read", a_addr0, a_wd0);
    if (a_v1 && a_r1) $display("a: req1 %s addr %0d data %02h", a_w1 ? "write" : "read", a_addr1, a_wd1);
    if (a_rv)         $display("a: rsp id %0d data %02h", a_rid, a_rdata);
  end

  initial begin
    int  seen;
    logic e0, e1, er;

    // ---- reset state
    do_reset();
    check("rst_qen", a_en, 0);
    check("rst_qaddr", a_qaddr, 0);
    check("rst_qoe", a_oe, 0);
    check("rst_qrf", a_rf, 0);
    check("rst_rspv", a_rv, 0);
    check("rst_miss", a_miss, 0);

    // ---- write addr 3 data A5, then read it back on requester 0
    step();                                   // cycle 1
    a_v0 = 1; a_w0 = 1; a_addr0 = 4'd3; a_wd0 = 8'hA5;
    #1 check("wr_ready0", a_r0, 1);
    check("wr_ready1", a_r1, 0);
    step();                                   // cycle 2: write on pins
    a_w0 = 0; a_wd0 = 8'hFF;
    check("wr_qwrite", a_wr, 1);
    check("wr_qen", a_en, 1);
    check("wr_qaddr", a_qaddr, 3);
    check("wr_qoe", a_oe, 1);
    check("wr_qdout", a_dout, 8'hA5);
    check("wr_qread", a_rd, 0);
    #1 check("wr_busy_ready", a_r0, 0);
    step();                                   // cycle 3: read handshake
    check("wr_done_qen", a_en, 0);
    check("rd_ready0", a_r0, 1);
    step();                                   // cycle 4: read on pins
    a_v0 = 0;
    check("rd_qread", a_rd, 1);
    check("rd_qen", a_en, 1);
    check("rd_qaddr", a_qaddr, 3);
    check("rd_qoe", a_oe, 0);
    step();                                   // cycle 5: capture
    check("cap_qen", a_en, 0);
    check("cap_rspv", a_rv, 0);
    step();                                   // cycle 6: response
    check("rsp_valid", a_rv, 1);
    check("rsp_data", a_rdata, 8'hA5);
    check("rsp_id", a_rid, 0);
    step();
    check("rsp_pulse", a_rv, 0);

    // ---- both requesters read continuously: grants alternate 0,1,0,1
    do_reset();
    a_v0 = 1; a_w0 = 0; a_addr0 = 4'd1;
    a_v1 = 1; a_w1 = 0; a_addr1 = 4'd2;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) step();
      if (k == 12) begin a_v0 = 0; a_v1 = 0; end
      #1;
      e0 = (k % 3 == 0) && (k < 12) && ((k / 3) % 2 == 0);
      e1 = (k % 3 == 0) && (k < 12) && ((k / 3) % 2 == 1);
      check("rr_ready0", a_r0, 32'(e0));
      check("rr_ready1", a_r1, 32'(e1));
      er = (k % 3 == 0) && (k > 0);
      check("rr_rspv", a_rv, 32'(er));
      if (er) begin
        check("rr_rspid", a_rid, 32'(((k / 3) - 1) % 2));
        check("rr_rspdata", a_rdata, (((k / 3) - 1) % 2 == 0) ? 32'h11 : 32'h22);
      end
    end

    // ---- idle refresh: bursts at cycles 17-18 and 33-34 after release
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) step();
      er = (k == 17) || (k == 18) || (k == 33) || (k == 34);
      check("ref_qrefresh", a_rf, 32'(er));
      check("ref_qen", a_en, 32'(er));
      check("ref_miss", a_miss, 0);
    end

    // ---- pending refresh raised as a read is accepted on requester 1
    do_reset();
    for (int k = 0; k < 15; k++) step();      // cycle 15
    a_v1 = 1; a_w1 = 0; a_addr1 = 4'd5;
    #1 check("pend_ready1", a_r1, 1);
    step();                                   // 16: access
    check("pend_qread", a_rd, 1);
    check("pend_qaddr", a_qaddr, 5);
    check("pend_busy16", a_r1, 0);
    step();                                   // 17: capture
    check("pend_cap_qread", a_rd, 0);
    check("pend_busy17", a_r1, 0);
    step();                                   // 18: idle, refresh pending
    check("pend_rspv", a_rv, 1);
    check("pend_rspid", a_rid, 1);
    check("pend_rspdata", a_rdata, 8'h55);
    check("pend_held18", a_r1, 0);
    check("pend_noref18", a_rf, 0);
    step();                                   // 19
    check("pend_ref19", a_rf, 1);
    check("pend_held19", a_r1, 0);
    step();                                   // 20
    check("pend_ref20", a_rf, 1);
    check("pend_held20", a_r1, 0);
    step();                                   // 21
    check("pend_ref21", a_rf, 0);
    check("pend_ready21", a_r1, 1);
    a_v1 = 0;

    // ---- reset during capture of a read
    do_reset();
    a_v0 = 1; a_w0 = 0; a_addr0 = 4'd1;
    #1 check("rc_ready0", a_r0, 1);
    step();                                   // 1: access
    a_v0 = 0;
    check("rc_qread", a_rd, 1);
    step();                                   // 2: capture
    rst_a = 1'b1;
    step();                                   // reset state
    check("rc_rspv", a_rv, 0);
    check("rc_qen", a_en, 0);
    check("rc_qread0", a_rd, 0);
    check("rc_qwrite", a_wr, 0);
    check("rc_qoe", a_oe, 0);
    check("rc_qaddr", a_qaddr, 0);
    rst_a = 1'b0;
    step();
    check("rc_rspv_after", a_rv, 0);
    for (int k = 2; k <= 17; k++) begin
      step();
      if (k == 16) check("rc_cnt_noref16", a_rf, 0);
      if (k == 17) check("rc_cnt_ref17", a_rf, 1);
    end

    // ---- instance b saturated: refresh must be reported as missed
    b_v0 = 1; b_w0 = 1; b_addr0 = 4'd7; b_wd0 = 8'h3C;
    b_v1 = 1; b_w1 = 0; b_addr1 = 4'd9;
    step();
    rst_b = 1'b0;
    check("b_rst_miss", b_miss, 0);
    seen = 0;
    for (int k = 0; k < 150; k++) begin
      step();
      if (b_miss) begin
        seen = 1;
        step();
        check("b_miss_pulse", b_miss, 0);
        break;
      end
    end
    check("b_miss_seen", seen, 1);
    b_v0 = 0; b_v1 = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qsram_access_controller.md
Name: qsram_access_controller

Overview:
Sequences all traffic to one SDR_QSRAM instance. Arbitrates two requesters (round-robin) and issues periodic refresh bursts. Drives the memory's Address/Enable/Read/Write/Refresh pins and the tri-state write-data driver, and returns read data with a tagged response. Sits between the bus-side masters and the QSRAM macro.

Parameters:
ADDR_WIDTH, 4, QSRAM address width
DATA_WIDTH, 8, QSRAM data width
REFRESH_INTERVAL, 64, cycles between refresh requests (>=8)
REFRESH_CYCLES, 2, cycles Refresh is held per burst (>=1)

Ports:
Clock  in  1  sole clock, rising edge
Reset  in  1  synchronous, active-high
Req0Valid  in  1  requester 0 command valid
Req0Write  in  1  1=write, 0=read
Req0Addr  in  ADDR_WIDTH  requester 0 address
Req0WData  in  DATA_WIDTH  requester 0 write data
Req0Ready  out  1  requester 0 accepted when Valid&&Ready
Req1Valid/Req1Write/Req1Addr/Req1WData/Req1Ready  as requester 0
RspValid  out  1  one-cycle read-data strobe
RspId  out  1  requester that issued the read
RspData  out  DATA_WIDTH  read data
QAddress  out  ADDR_WIDTH  to QSRAM Address
QEnable  out  1  to QSRAM Enable
QRead  out  1  to QSRAM Read
QWrite  out  1  to QSRAM Write
QRefresh  out  1  to QSRAM Refresh
QDataOut  out  DATA_WIDTH  value for inoutData driver
QDataOutEn  out  1  enables inoutData driver
QDataIn  in  DATA_WIDTH  sampled inoutData
RefreshMissed  out  1  one-cycle pulse: interval expired with refresh still pending

Behaviour:
- Reset: state IDLE; all outputs 0; refresh counter = REFRESH_INTERVAL-1; RefreshPending=0; LastGrant=1 (requester 0 wins the first tie).
- All Q* outputs, Rsp*, and RefreshMissed are registered. ReqNReady is combinational from state, pending, and Valid.
- Refresh counter: decrements every cycle in every state. At 0 it reloads REFRESH_INTERVAL-1 and sets RefreshPending. If RefreshPending is already 1, RefreshMissed pulses and pending stays 1.
- States: IDLE, ACCESS, CAPTURE, REFRESH.
- IDLE, RefreshPending=1: both Ready=0. Next state REFRESH and pending clears. Refresh beats requests.
- IDLE, no pending, any Valid:
  - Grant one requester: the only valid one, or on a tie the one != LastGrant.
  - Ready=1 only for the granted requester. Latch addr/data/write/id. LastGrant=id. Next state ACCESS.
- ACCESS (1 cycle):
  - QEnable=1; QAddress=latched address.
  - Write: QWrite=1, QDataOutEn=1, QDataOut=data. Next state IDLE.
  - Read: QRead=1, QDataOutEn=0. Next state CAPTURE.
- CAPTURE (1 cycle): QEnable=QRead=0. QDataIn is registered into RspData at the end of the cycle. Next state IDLE. RspValid=1 and RspId=id during the following cycle.
- Latency, handshake at cycle T:
  - Read: command at T+1, RspValid at T+3.
  - Write: command at T+1.
  - Next handshake possible at T+2 (write) or T+3 (read). RspValid may coincide with a new handshake.
- REFRESH: QEnable=1, QRefresh=1, QRead=QWrite=QDataOutEn=0 for exactly REFRESH_CYCLES cycles, then IDLE.
- Invariants:
  - At most one of QRead/QWrite/QRefresh is high.
  - QDataOutEn is high only with QWrite.
  - Refresh never preempts an in-flight access; it waits for IDLE.
- Valid dropped before a handshake: no command issued. Write payload is ignored for reads.
- Reset asserted mid-operation: the next cycle is the reset state. Any in-flight read produces no RspValid; QDataOutEn drops immediately.

Test Plan:
- ADDR=4/DATA=8, INTERVAL=64. Req0 write addr 3 data 0xA5, then Req0 read addr 3 with QDataIn model returning 0xA5 -> QWrite pulse with QAddress=3, QDataOutEn=1; read RspValid 2 cycles after its command cycle, RspData=0xA5, RspId=0.
- Both requesters valid continuously with reads -> grants alternate 0,1,0,1. First grant goes to 0. Each RspId matches its grantor; no cycle with both Ready high.
- INTERVAL=16, CYCLES=2, no traffic -> QRefresh high for 2 cycles every 16 cycles, first burst beginning 17 cycles after Reset release; QEnable high with it.
- INTERVAL=16, pending set on the cycle a read is accepted -> read completes (ACCESS, CAPTURE), then REFRESH 2 cycles. Requests are held off (Ready=0) until refresh ends.
- INTERVAL=8, CYCLES=8 with requests saturating -> RefreshMissed pulses. Assert QRead/QWrite/QRefresh are one-hot-or-zero throughout.
- Reset asserted in CAPTURE of a read -> no RspValid. All Q* outputs are 0 the next cycle. Counter restarts at INTERVAL-1.
